arm32_fetch_unit: RTL and testbench

Instruction fetch stage for the ARM32 processor. It reads the byte-wide unified RAM, assembles big-endian 32-bit instruction words, and buffers them in a small prefetch FIFO. It presents them to the decode stage through a valid/ready handshake. Branch redirects from write-back flush the buffer and restart fetch at the target address.

---
 rtl/arm32_fetch_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_arm32_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm32_fetch_unit.sv
// ---------------------------------------------------------------------------
// arm32_fetch_unit
//
// Instruction fetch stage. Reads the byte-wide unified RAM one byte per cycle,
// assembles big-endian 32-bit words and queues {word, pc} in a small prefetch
// FIFO that feeds decode through a valid/ready handshake. A branch redirect
// from write-back flushes everything and restarts fetch at the target.
//
// Optional feature (compile-time macro ARM32_FETCH_ALIGN_TRAP_EN):
//   defined   - a redirect to a non-word-aligned target flushes and halts
//               fetch with fault=1 until reset.
//   undefined - target[1:0] is forced to 00 and fault is tied low.
//
// Parameters:
//   DEPTH     prefetch FIFO depth in words (power of two, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   mem_rd_en/mem_addr    byte read request to RAM (addr held when idle)
//   mem_rdata             read data, one cycle after the request
//   br_valid/br_target    single-cycle redirect pulse and byte target
//   ins_valid/ins_ready   handshake to decode
//   ins_data/ins_pc       head-of-FIFO instruction word and its address
//   fault                 misaligned-redirect trap indicator
// ---------------------------------------------------------------------------
module arm32_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e                   state_q,     state_d;
  logic [31:0]              fetch_pc_q,  fetch_pc_d;
  logic [1:0]               bcnt_q,      bcnt_d;
  logic                     epoch_q,     epoch_d;
  // Tag of the byte request issued last cycle.
  logic                     rsp_vld_q,   rsp_vld_d;
  logic                     rsp_epoch_q, rsp_epoch_d;
  logic                     rsp_last_q,  rsp_last_d;
  logic [31:0]              rsp_pc_q,    rsp_pc_d;
  logic [31:0]              asm_q,       asm_d;
  logic [31:0]              mem_addr_q,  mem_addr_d;
  logic [DEPTH-1:0][31:0]   fifo_data_q, fifo_data_d;
  logic [DEPTH-1:0][31:0]   fifo_pc_q,   fifo_pc_d;
  logic [AW-1:0]            rd_ptr_q,    rd_ptr_d;
  logic [AW-1:0]            wr_ptr_q,    wr_ptr_d;
  logic [CW-1:0]            count_q,     count_d;
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
  logic                     fault_q,     fault_d;
`endif

  logic        rsp_ok;
  logic        push;
  logic        pop;
  logic        room;
  logic        issue;
  logic        br_take;
  logic        br_misal;
  logic [31:0] br_tgt;

  // Redirect target handling differs only in alignment treatment.
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
  assign br_tgt   = br_target;
  assign br_misal = |br_target[1:0];
`else
  assign br_tgt   = br_target & ~32'h3;
  assign br_misal = 1'b0;
`endif

  // Once halted, every redirect is ignored; only reset leaves HALT.
  assign br_take = br_valid && (state_q != S_HALT);

  // A returning byte is used only if no redirect happened since its request.
  assign rsp_ok = rsp_vld_q && (rsp_epoch_q == epoch_q);
  assign push   = rsp_ok && rsp_last_q;
  assign pop    = (count_q != '0) && ins_ready;

  // At a word boundary the only word still in flight is the one whose last
  // byte returns this cycle, so counting that push is enough to guarantee a
  // slot for the word about to start. Pops are ignored here (conservative).
  assign room  = ({1'b0, count_q} + (CW+1)'(push)) < (CW+1)'(DEPTH);
  assign issue = (state_q == S_FETCH) && ((bcnt_q != 2'd0) || room);

  // Gated by reset_n so no request escapes while reset is held; the first
  // request then appears in the very first cycle after release.
  assign mem_rd_en = reset_n && issue;
  assign mem_addr  = mem_rd_en ? (fetch_pc_q + {30'd0, bcnt_q}) : mem_addr_q;

  assign ins_valid = (count_q != '0);
  assign ins_data  = fifo_data_q[rd_ptr_q];
  assign ins_pc    = fifo_pc_q[rd_ptr_q];

`ifdef ARM32_FETCH_ALIGN_TRAP_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    bcnt_d      = bcnt_q;
    epoch_d     = epoch_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
    fault_d     = fault_q;
`endif

    rsp_vld_d   = mem_rd_en;
    rsp_epoch_d = epoch_q;
    rsp_last_d  = (bcnt_q == 2'd3);
    rsp_pc_d    = fetch_pc_q;

    // Big-endian assembly: first byte ends up in [31:24].
    if (rsp_ok) asm_d = {asm_q[23:0], mem_rdata};

    if (issue) begin
      bcnt_d = 2'(bcnt_q + 2'd1);
      if (bcnt_q == 2'd3) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    unique case (state_q)
      S_FETCH: if (!issue) state_d = S_STALL;
      S_STALL: if (count_q < CW'(DEPTH)) state_d = S_FETCH;
      default: state_d = state_q;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = {asm_q[23:0], mem_rdata};
      fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
      wr_ptr_d              = AW'(wr_ptr_q + 1'b1);
    end
    if (pop) rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Redirect overrides everything above, including a same-cycle pop and
    // a byte returning this cycle. Flipping the epoch kills the byte
    // requested this cycle when it returns next cycle.
    if (br_take) begin
      epoch_d    = ~epoch_q;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      asm_d      = '0;
      bcnt_d     = 2'd0;
      fetch_pc_d = br_tgt;
      state_d    = S_FETCH;
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
      if (br_misal) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
`else
      if (br_misal) state_d = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RESET_PC;
      bcnt_q      <= 2'd0;
      epoch_q     <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_epoch_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_pc_q    <= 32'd0;
      asm_q       <= 32'd0;
      mem_addr_q  <= 32'd0;
      fifo_data_q <= '0;
      fifo_pc_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      bcnt_q      <= bcnt_d;
      epoch_q     <= epoch_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_epoch_q <= rsp_epoch_d;
      rsp_last_q  <= rsp_last_d;
      rsp_pc_q    <= rsp_pc_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_arm32_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_arm32_fetch_unit
//
// Self-checking bench for arm32_fetch_unit (DEPTH=2, RESET_PC=0). A byte RAM
// model answers requests one cycle later; expected {word, pc} pairs are queued
// by each scenario and compared whenever decode accepts a word. Scenario tasks
// also check cycle-exact timing inline. Honors ARM32_FETCH_ALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_arm32_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        br_valid;
  logic [31:0] br_target;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  logic [63:0] exp_q[$];

  logic        req_v = 1'b0;
  logic [31:0] req_a = 32'h0;

  arm32_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .br_valid(br_valid), .br_target(br_target),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'd0: ram_byte = 8'hE3;
      32'd1: ram_byte = 8'hA0;
      32'd2: ram_byte = 8'h10;
      32'd3: ram_byte = 8'h05;
      32'd4: ram_byte = 8'hE2;
      32'd5: ram_byte = 8'h81;
      32'd6: ram_byte = 8'h20;
      32'd7: ram_byte = 8'h01;
      default: ram_byte = a[7:0] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    word_at = {ram_byte(a), ram_byte(a1), ram_byte(a2), ram_byte(a3)};
  endfunction

  // RAM model: capture the request mid-cycle, return data on the next edge.
  always @(negedge clk) begin
    req_v = mem_rd_en;
    req_a = mem_addr;
    if (reset_n === 1'b1 && mem_rd_en === 1'b1) req_cnt++;
  end
  always @(posedge clk) if (req_v) mem_rdata <= ram_byte(req_a);

  // Scoreboard: each accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ins_valid === 1'b1 && ins_ready === 1'b1 && br_valid !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h pc=%h want none", ins_data, ins_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({ins_data, ins_pc} !== e) begin
          errors++;
          $display("FAIL sb_word got data=%h pc=%h want data=%h pc=%h", ins_data, ins_pc, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hold reset two cycles, release; caller is then in cycle 0.
  task automatic start(input logic rdy);
    reset_n   = 1'b0;
    ins_ready = rdy;
    br_valid  = 1'b0;
    br_target = 32'h0;
    step();
    step();
    reset_n = 1'b1;
    exp_q.delete();
    req_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ins_ready = 1'b1; br_valid = 1'b0; br_target = 32'h0;
    step(); step(); step();
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0", mem_rd_en); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ins_valid); end
    checks++; if (ins_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", ins_data); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", ins_pc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
  endtask

  task automatic test_first_word();
    start(1'b1);
    exp_q.push_back({32'hE3A01005, 32'h0});
    exp_q.push_back({32'hE2812001, 32'h4});
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 32'(c)) begin
        errors++; $display("FAIL fw_req c=%0d got en=%b addr=%h want en=1 addr=%h", c, mem_rd_en, mem_addr, c);
      end
      checks++;
      if (ins_valid !== ((c == 5) || (c == 9))) begin
        errors++; $display("FAIL fw_valid c=%0d got %b want %b", c, ins_valid, (c == 5) || (c == 9));
      end
      if (c == 5) begin
        checks++;
        if (ins_data !== 32'hE3A01005 || ins_pc !== 32'h0) begin
          errors++; $display("FAIL fw_word0 got %h@%h want E3A01005@0", ins_data, ins_pc);
        end
      end
      if (c == 9) begin
        checks++;
        if (ins_data !== 32'hE2812001 || ins_pc !== 32'h4) begin
          errors++; $display("FAIL fw_word1 got %h@%h want E2812001@4", ins_data, ins_pc);
        end
      end
      step();
    end
    ins_ready = 1'b0;
    repeat (4) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fw_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_full_stall();
    start(1'b0);
    exp_q.push_back({32'hE3A01005, 32'h0});
    repeat (20) step();
    checks++; if (req_cnt != 8) begin errors++; $display("FAIL st_reqs got %0d want 8", req_cnt); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL st_idle got %b want 0", mem_rd_en); end
    checks++;
    if (ins_valid !== 1'b1 || ins_data !== 32'hE3A01005 || ins_pc !== 32'h0) begin
      errors++; $display("FAIL st_head got v=%b %h@%h want v=1 E3A01005@0", ins_valid, ins_data, ins_pc);
    end
    ins_ready = 1'b1;  // pop in cycle P
    step();
    ins_ready = 1'b0;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL st_p1 got %b want 0", mem_rd_en); end
    step();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h8) begin
      errors++; $display("FAIL st_p2 got en=%b addr=%h want en=1 addr=8", mem_rd_en, mem_addr);
    end
    repeat (3) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL st_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    start(1'b1);
    exp_q.push_back({32'hE3A01005, 32'h0});
    repeat (6) step();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h6) begin
      errors++; $display("FAIL br_pre got en=%b addr=%h want en=1 addr=6", mem_rd_en, mem_addr);
    end
    br_valid = 1'b1; br_target = 32'h40;
    exp_q.push_back({word_at(32'h40), 32'h40});
    step();
    br_valid = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL br_req got en=%b addr=%h want en=1 addr=40", mem_rd_en, mem_addr);
    end
    for (int c = 7; c < 12; c++) begin
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL br_gap c=%0d got %b want 0", c, ins_valid); end
      step();
    end
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h40 || ins_data !== word_at(32'h40)) begin
      errors++; $display("FAIL br_tgt got v=%b %h@%h want v=1 %h@40", ins_valid, ins_data, ins_pc, word_at(32'h40));
    end
    step();
    ins_ready = 1'b0;
    repeat (2) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL br_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_pop();
    start(1'b1);
    repeat (5) step();
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL bp_head got %b want 1", ins_valid); end
    br_valid = 1'b1; br_target = 32'h80;
    exp_q.push_back({word_at(32'h80), 32'h80});
    step();
    br_valid = 1'b0;
    for (int c = 6; c < 11; c++) begin
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL bp_gap c=%0d got %b want 0", c, ins_valid); end
      step();
    end
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h80) begin
      errors++; $display("FAIL bp_tgt got v=%b pc=%h want v=1 pc=80", ins_valid, ins_pc);
    end
    step();
    ins_ready = 1'b0;
    repeat (2) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    start(1'b0);
    br_valid = 1'b1; br_target = 32'hFFFFFFFC;
    exp_q.push_back({word_at(32'hFFFFFFFC), 32'hFFFFFFFC});
    step();
    br_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      logic [31:0] want;
      want = 32'hFFFFFFFC + 32'(c - 1);
      checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== want) begin
        errors++; $display("FAIL wr_req c=%0d got en=%b addr=%h want en=1 addr=%h", c, mem_rd_en, mem_addr, want);
      end
      step();
    end
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL wr_word got v=%b pc=%h want v=1 pc=FFFFFFFC", ins_valid, ins_pc);
    end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    repeat (2) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wr_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_misaligned();
    start(1'b1);
    br_valid = 1'b1; br_target = 32'h42;
`ifdef ARM32_FETCH_ALIGN_TRAP_EN
    step();
    br_valid = 1'b0;
    for (int c = 1; c < 9; c++) begin
      checks++;
      if (fault !== 1'b1 || mem_rd_en !== 1'b0 || ins_valid !== 1'b0) begin
        errors++; $display("FAIL ma_halt c=%0d got f=%b en=%b v=%b want f=1 en=0 v=0", c, fault, mem_rd_en, ins_valid);
      end
      // An aligned redirect while halted must have no effect.
      br_valid  = (c == 3);
      br_target = 32'h40;
      step();
    end
    br_valid = 1'b0;
`else
    exp_q.push_back({word_at(32'h40), 32'h40});
    step();
    br_valid = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h40 || fault !== 1'b0) begin
      errors++; $display("FAIL ma_req got en=%b addr=%h f=%b want en=1 addr=40 f=0", mem_rd_en, mem_addr, fault);
    end
    repeat (5) step();
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h40) begin
      errors++; $display("FAIL ma_word got v=%b pc=%h want v=1 pc=40", ins_valid, ins_pc);
    end
    step();
    ins_ready = 1'b0;
    repeat (2) step();
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ma_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midword();
    start(1'b1);
    repeat (2) step();
    reset_n = 1'b0;
    step(); step();
    checks++;
    if (mem_rd_en !== 1'b0 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL rm_hold got en=%b v=%b want en=0 v=0", mem_rd_en, ins_valid);
    end
    reset_n = 1'b1;
    exp_q.push_back({32'hE3A01005, 32'h0});
    #1;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rm_restart got en=%b addr=%h want en=1 addr=0", mem_rd_en, mem_addr);
    end
    repeat (5) step();
    checks++;
    if (ins_valid !== 1'b1 || ins_data !== 32'hE3A01005 || ins_pc !== 32'h0) begin
      errors++; $display("FAIL rm_word got v=%b %h@%h want v=1 E3A01005@0", ins_valid, ins_data, ins_pc);
    end
    step();
    ins_ready = 1'b0;
    repeat (2) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_drain got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0; ins_ready = 1'b0; br_valid = 1'b0; br_target = 32'h0;
    test_reset();
    test_first_word();
    test_full_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_misaligned();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
